dco_phase_accumulator: RTL and testbench
========================================

# dco_phase_accumulator

Digitally controlled oscillator placed downstream of the digital loop filter. It accepts the filter's signed 8-bit control word over a valid/ready handshake and converts it to a saturated frequency control word (FCW). It integrates the FCW in a phase accumulator and produces the recovered clock, a wrap strobe and a quantised phase sample that closes the loop back to the phase detector.

## Interface
- CTRL_WIDTH, 8: signed control word width; matches loop filter output.
- ACC_WIDTH, 24: phase accumulator and FCW width.
- FCW_NOM, 24'h100000: free-running (open-loop) FCW.
- GAIN_SHIFT, 8: left shift applied to the control word, i.e. DCO gain.
- FCW_MIN, 24'h010000: lower FCW clamp.
- FCW_MAX, 24'h400000: upper FCW clamp.
- PHASE_WIDTH, 8: width of the quantised phase output.
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- loop_en  in  1  1 = closed loop; 0 = force OPEN state.
- hold_req  in  1  freeze FCW at its current value while in closed loop.
- ctrl_in  in  CTRL_WIDTH  signed control word from the loop filter.
- ctrl_valid  in  1  ctrl_in is valid.
- ctrl_ready  out  1  block accepts ctrl_in this cycle.
- fcw_out  out  ACC_WIDTH  registered active FCW.
- sat_flag  out  1  fcw_out is the clamped value from the last accepted word.
- phase_out  out  PHASE_WIDTH  top PHASE_WIDTH bits of the accumulator (see Configuration).
- dco_clk_out  out  1  accumulator MSB.
- wrap_pulse  out  1  one-cycle strobe on accumulator overflow.

## Operation
- States:
  - OPEN (reset state): fcw_out is forced to FCW_NOM, sat_flag is 0 and ctrl_ready is 0.
  - TRACK: ctrl_ready is 1.
  - HOLD: fcw_out is frozen and ctrl_ready is 0.
- Transitions:
  - OPEN→TRACK when loop_en=1.
  - TRACK→HOLD when hold_req=1.
  - HOLD→TRACK when hold_req=0.
  - TRACK or HOLD→OPEN whenever loop_en=0; this has priority over hold_req.
- Transfer: a word transfers when ctrl_valid & ctrl_ready. ctrl_ready is a function of the registered state only and does not depend on ctrl_valid.
- FCW calculation:
  - Sign-extend ctrl_in to ACC_WIDTH+2 bits, shift left by GAIN_SHIFT, then add FCW_NOM, all in signed ACC_WIDTH+2 arithmetic.
  - Clamp the result to [FCW_MIN, FCW_MAX].
  - The clamped value is registered into fcw_out, and sat_flag is registered as 1 if the clamp engaged.
- No transfer in TRACK: fcw_out and sat_flag hold their values.
- On entry to OPEN: fcw_out reloads FCW_NOM and sat_flag clears on the same edge.
- Accumulator: acc <= acc + fcw_out, modulo 2^ACC_WIDTH, every cycle in all states. The carry out of the addition is registered as wrap_pulse.
- Outputs from the accumulator: dco_clk_out = acc[ACC_WIDTH-1]; phase_out = acc[ACC_WIDTH-1 -: PHASE_WIDTH].
- Reset mid-operation: everything returns to its reset value on the next edge; any pending word is discarded.

## Timing
- Reset values:
  - state = OPEN, acc = 0, fcw_out = FCW_NOM.
  - sat_flag = 0, ctrl_ready = 0, phase_out = 0, dco_clk_out = 0, wrap_pulse = 0.
- Control path: a word transferred on edge N appears on fcw_out after edge N. It first affects acc on edge N+1.
- State change: loop_en or hold_req sampled on edge N updates state at N. ctrl_ready changes after that edge, so it follows inputs with 1-cycle latency.
- Simultaneous transfer and hold_req=1 on the same edge: the word is accepted and the state goes to HOLD, freezing the newly computed FCW.
- Simultaneous transfer and loop_en=0: the word is dropped and fcw_out becomes FCW_NOM.
- wrap_pulse: high for exactly one cycle after each overflow edge. With FCW_NOM it repeats with a period of 16 cycles.

## Configuration
- NCO_DITHER_EN defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, stepped every cycle, reset to the seed) is included.
  - Bits [3:0] of the LFSR are added to acc bits [ACC_WIDTH-PHASE_WIDTH-1 -: 4] before truncation to phase_out, saturating at all-ones.
  - acc, fcw_out and dco_clk_out are unaffected.
- NCO_DITHER_EN undefined: no LFSR exists and phase_out is the plain truncation.

## Test plan
- Reset, then loop_en=0 for 40 cycles -> fcw_out=24'h100000, wrap_pulse every 16 cycles, dco_clk_out 50% duty, ctrl_ready=0.
- loop_en=1, ctrl_in=8'sd127 with valid -> ctrl_ready=1, fcw_out=24'h107F00 one edge after transfer, sat_flag=0.
- GAIN_SHIFT=14, ctrl_in=-128 -> fcw_out clamps to 24'h010000 and sat_flag=1; then ctrl_in=0 -> fcw_out=24'h100000 and sat_flag=0.
- In TRACK, hold_req=1 while ctrl_in=8'sd10 and valid are asserted on the same edge -> fcw_out=24'h100A00, then ctrl_ready=0 and fcw_out is held while ctrl_in changes to -50.
- In HOLD, deassert loop_en and assert rstn=0 mid-run -> OPEN with fcw_out=FCW_NOM; after reset, acc=0, phase_out=0 and wrap_pulse=0 on the next edge.

Source files
------------

// File: rtl/dco_phase_accumulator.sv
// rtl/dco_phase_accumulator.sv - DCO: control word to saturated FCW, phase accumulator, recovered clock
// Optional phase dither is enabled by defining NCO_DITHER_EN.
module dco_phase_accumulator #(
  parameter int                   CTRL_WIDTH  = 8,
  parameter int                   ACC_WIDTH   = 24,
  parameter logic [ACC_WIDTH-1:0] FCW_NOM     = 24'h100000,
  parameter int                   GAIN_SHIFT  = 8,
  parameter logic [ACC_WIDTH-1:0] FCW_MIN     = 24'h010000,
  parameter logic [ACC_WIDTH-1:0] FCW_MAX     = 24'h400000,
  parameter int                   PHASE_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         loop_en,
  input  logic                         hold_req,
  input  logic signed [CTRL_WIDTH-1:0] ctrl_in,
  input  logic                         ctrl_valid,
  output logic                         ctrl_ready,
  output logic [ACC_WIDTH-1:0]         fcw_out,
  output logic                         sat_flag,
  output logic [PHASE_WIDTH-1:0]       phase_out,
  output logic                         dco_clk_out,
  output logic                         wrap_pulse
);

  localparam logic [1:0] ST_OPEN  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam int EXT_WIDTH = ACC_WIDTH + 2;

  logic [1:0]                  state;
  logic [1:0]                  state_nxt;
  logic [ACC_WIDTH-1:0]        acc;
  logic [ACC_WIDTH:0]          acc_sum;
  logic                        xfer;

  logic signed [EXT_WIDTH-1:0] ctrl_ext;
  logic signed [EXT_WIDTH-1:0] fcw_raw;
  logic signed [EXT_WIDTH-1:0] fcw_min_ext;
  logic signed [EXT_WIDTH-1:0] fcw_max_ext;
  logic [ACC_WIDTH-1:0]        fcw_clamped;
  logic                        clamp_hit;

  // Ready comes from registered state only, so it never combinationally follows ctrl_valid.
  assign ctrl_ready = (state == ST_TRACK);
  assign xfer       = ctrl_valid & ctrl_ready;

  always_comb begin
    state_nxt = state;
    if (!loop_en) begin
      state_nxt = ST_OPEN;
    end else begin
      case (state)
        ST_OPEN:  state_nxt = ST_TRACK;
        ST_TRACK: state_nxt = hold_req ? ST_HOLD : ST_TRACK;
        ST_HOLD:  state_nxt = hold_req ? ST_HOLD : ST_TRACK;
        default:  state_nxt = ST_OPEN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_OPEN;
    end else begin
      state <= state_nxt;
    end
  end

  // Two guard bits keep the most negative shifted word plus FCW_NOM representable.
  assign ctrl_ext    = {{(EXT_WIDTH-CTRL_WIDTH){ctrl_in[CTRL_WIDTH-1]}}, ctrl_in};
  assign fcw_min_ext = $signed({2'b00, FCW_MIN});
  assign fcw_max_ext = $signed({2'b00, FCW_MAX});
  assign fcw_raw     = (ctrl_ext <<< GAIN_SHIFT) + $signed({2'b00, FCW_NOM});

  always_comb begin
    fcw_clamped = fcw_raw[ACC_WIDTH-1:0];
    clamp_hit   = 1'b0;
    if (fcw_raw < fcw_min_ext) begin
      fcw_clamped = FCW_MIN;
      clamp_hit   = 1'b1;
    end else if (fcw_raw > fcw_max_ext) begin
      fcw_clamped = FCW_MAX;
      clamp_hit   = 1'b1;
    end
  end

  // Dropping loop_en wins over a same-edge transfer: the word is discarded.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fcw_out  <= FCW_NOM;
      sat_flag <= 1'b0;
    end else if (!loop_en || state == ST_OPEN) begin
      fcw_out  <= FCW_NOM;
      sat_flag <= 1'b0;
    end else if (xfer) begin
      fcw_out  <= fcw_clamped;
      sat_flag <= clamp_hit;
    end
  end

  assign acc_sum = {1'b0, acc} + {1'b0, fcw_out};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc        <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      acc        <= acc_sum[ACC_WIDTH-1:0];
      wrap_pulse <= acc_sum[ACC_WIDTH];
    end
  end

  assign dco_clk_out = acc[ACC_WIDTH-1];

`ifdef NCO_DITHER_EN
  localparam int DW = PHASE_WIDTH + 4;

  logic [15:0]   lfsr;
  logic [DW-1:0] phase_wide;
  logic [DW:0]   phase_sum;
  logic [DW-1:0] phase_dith;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Dither lands on the four bits just below the phase window; saturate instead of wrapping.
  assign phase_wide = acc[ACC_WIDTH-1 -: DW];
  assign phase_sum  = {1'b0, phase_wide} + {{(DW-3){1'b0}}, lfsr[3:0]};
  assign phase_dith = phase_sum[DW] ? {DW{1'b1}} : phase_sum[DW-1:0];
  assign phase_out  = phase_dith[DW-1 -: PHASE_WIDTH];
`else
  assign phase_out = acc[ACC_WIDTH-1 -: PHASE_WIDTH];
`endif

endmodule

// File: tb/tb_dco_phase_accumulator.sv
// tb/tb_dco_phase_accumulator.sv - randomized self-checking bench for dco_phase_accumulator
module tb_dco_phase_accumulator;

  logic              clk = 1'b0;
  logic              rstn;
  logic              loop_en;
  logic              hold_req;
  logic signed [7:0] ctrl_in;
  logic              ctrl_valid;

  logic [1:0]        ready_o;
  logic [1:0][23:0]  fcw_o;
  logic [1:0]        sat_o;
  logic [1:0][7:0]   phase_o;
  logic [1:0]        dco_o;
  logic [1:0]        wrap_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dco_phase_accumulator dut (
    .clk(clk), .rstn(rstn), .loop_en(loop_en), .hold_req(hold_req),
    .ctrl_in(ctrl_in), .ctrl_valid(ctrl_valid), .ctrl_ready(ready_o[0]),
    .fcw_out(fcw_o[0]), .sat_flag(sat_o[0]), .phase_out(phase_o[0]),
    .dco_clk_out(dco_o[0]), .wrap_pulse(wrap_o[0])
  );

  dco_phase_accumulator #(.GAIN_SHIFT(14)) dut_g14 (
    .clk(clk), .rstn(rstn), .loop_en(loop_en), .hold_req(hold_req),
    .ctrl_in(ctrl_in), .ctrl_valid(ctrl_valid), .ctrl_ready(ready_o[1]),
    .fcw_out(fcw_o[1]), .sat_flag(sat_o[1]), .phase_out(phase_o[1]),
    .dco_clk_out(dco_o[1]), .wrap_pulse(wrap_o[1])
  );

  // Reference model: 0 = open, 1 = track, 2 = hold; phase and FCW as plain integers.
  int     m_mode;
  longint m_acc [2];
  longint m_fcw [2];
  bit     m_sat [2];
  bit     m_wrap[2];
  int     gains [2] = '{8, 14};

  localparam longint NOM  = 64'h100000;
  localparam longint FMIN = 64'h010000;
  localparam longint FMAX = 64'h400000;
  localparam longint MOD  = 64'h1000000;

  task automatic model_step();
    longint t;
    if (!rstn) begin
      m_mode = 0;
      for (int i = 0; i < 2; i++) begin
        m_acc[i] = 0; m_fcw[i] = NOM; m_sat[i] = 0; m_wrap[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        t = m_acc[i] + m_fcw[i];
        m_wrap[i] = (t >= MOD);
        m_acc[i]  = t % MOD;
      end
      if (!loop_en) begin
        m_mode = 0;
        for (int i = 0; i < 2; i++) begin m_fcw[i] = NOM; m_sat[i] = 0; end
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else begin
        if (m_mode == 1 && ctrl_valid) begin
          for (int i = 0; i < 2; i++) begin
            t = longint'(ctrl_in) * (longint'(1) << gains[i]) + NOM;
            m_sat[i] = (t < FMIN) || (t > FMAX);
            m_fcw[i] = (t < FMIN) ? FMIN : (t > FMAX) ? FMAX : t;
          end
        end
        m_mode = hold_req ? 2 : 1;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 0; loop_en = 0; hold_req = 0; ctrl_in = 0; ctrl_valid = 0;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      checks += 6;
      if (fcw_o[i] !== 24'h100000) begin errors++; $display("FAIL reset_fcw[%0d]: got %h expected 100000", i, fcw_o[i]); end
      if (sat_o[i] !== 1'b0) begin errors++; $display("FAIL reset_sat[%0d]: got %b expected 0", i, sat_o[i]); end
      if (ready_o[i] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b expected 0", i, ready_o[i]); end
      if (phase_o[i] !== 8'h00) begin errors++; $display("FAIL reset_phase[%0d]: got %h expected 00", i, phase_o[i]); end
      if (dco_o[i] !== 1'b0) begin errors++; $display("FAIL reset_dco[%0d]: got %b expected 0", i, dco_o[i]); end
      if (wrap_o[i] !== 1'b0) begin errors++; $display("FAIL reset_wrap[%0d]: got %b expected 0", i, wrap_o[i]); end
    end
  endtask

  task automatic test_open_run();
    int wraps = 0, last_wrap = -1, dco_high = 0;
    rstn = 1; loop_en = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      checks += 3;
      if (fcw_o[0] !== 24'h100000) begin errors++; $display("FAIL open_fcw c%0d: got %h expected 100000", c, fcw_o[0]); end
      if (ready_o[0] !== 1'b0) begin errors++; $display("FAIL open_ready c%0d: got %b expected 0", c, ready_o[0]); end
      if (wrap_o[0] !== m_wrap[0]) begin errors++; $display("FAIL open_wrap c%0d: got %b expected %b", c, wrap_o[0], m_wrap[0]); end
      if (c <= 32 && dco_o[0] === 1'b1) dco_high++;
      if (wrap_o[0] === 1'b1) begin
        if (last_wrap >= 0) begin
          checks++;
          if (c - last_wrap != 16) begin errors++; $display("FAIL open_wrap_period: got %0d expected 16", c - last_wrap); end
        end
        last_wrap = c; wraps++;
      end
    end
    checks += 2;
    if (wraps != 2) begin errors++; $display("FAIL open_wrap_count: got %0d expected 2", wraps); end
    if (dco_high != 16) begin errors++; $display("FAIL open_dco_duty: got %0d high of 32 expected 16", dco_high); end
  endtask

  task automatic test_track_basic();
    loop_en = 1; ctrl_valid = 0;
    tick();
    checks += 2;
    if (ready_o !== 2'b11) begin errors++; $display("FAIL track_ready: got %b expected 11", ready_o); end
    if (fcw_o[0] !== 24'h100000) begin errors++; $display("FAIL track_fcw_idle: got %h expected 100000", fcw_o[0]); end
    ctrl_in = 8'sd127; ctrl_valid = 1;
    tick();
    ctrl_valid = 0;
    checks += 3;
    if (fcw_o[0] !== 24'h107F00) begin errors++; $display("FAIL track_fcw_127: got %h expected 107f00", fcw_o[0]); end
    if (sat_o[0] !== 1'b0) begin errors++; $display("FAIL track_sat_127: got %b expected 0", sat_o[0]); end
    if (fcw_o[1] !== 24'h2FC000) begin errors++; $display("FAIL track_fcw_127_g14: got %h expected 2fc000", fcw_o[1]); end
    tick();
    checks++;
    if (fcw_o[0] !== 24'h107F00) begin errors++; $display("FAIL track_fcw_idle_hold: got %h expected 107f00", fcw_o[0]); end
  endtask

  task automatic test_clamp();
    ctrl_in = -8'sd128; ctrl_valid = 1;
    tick();
    checks += 4;
    if (fcw_o[1] !== 24'h010000) begin errors++; $display("FAIL clamp_fcw_g14: got %h expected 010000", fcw_o[1]); end
    if (sat_o[1] !== 1'b1) begin errors++; $display("FAIL clamp_sat_g14: got %b expected 1", sat_o[1]); end
    if (fcw_o[0] !== 24'h0F8000) begin errors++; $display("FAIL clamp_fcw_g8: got %h expected 0f8000", fcw_o[0]); end
    if (sat_o[0] !== 1'b0) begin errors++; $display("FAIL clamp_sat_g8: got %b expected 0", sat_o[0]); end
    ctrl_in = 0;
    tick();
    ctrl_valid = 0;
    checks += 2;
    if (fcw_o[1] !== 24'h100000) begin errors++; $display("FAIL unclamp_fcw_g14: got %h expected 100000", fcw_o[1]); end
    if (sat_o[1] !== 1'b0) begin errors++; $display("FAIL unclamp_sat_g14: got %b expected 0", sat_o[1]); end
  endtask

  task automatic test_hold();
    hold_req = 1; ctrl_in = 8'sd10; ctrl_valid = 1;
    tick();
    checks += 3;
    if (fcw_o[0] !== 24'h100A00) begin errors++; $display("FAIL hold_fcw_capture: got %h expected 100a00", fcw_o[0]); end
    if (fcw_o[1] !== 24'h128000) begin errors++; $display("FAIL hold_fcw_capture_g14: got %h expected 128000", fcw_o[1]); end
    if (ready_o[0] !== 1'b0) begin errors++; $display("FAIL hold_ready: got %b expected 0", ready_o[0]); end
    ctrl_in = -8'sd50;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks += 2;
      if (fcw_o[0] !== 24'h100A00) begin errors++; $display("FAIL hold_fcw_frozen c%0d: got %h expected 100a00", c, fcw_o[0]); end
      if (ready_o[0] !== 1'b0) begin errors++; $display("FAIL hold_ready_frozen c%0d: got %b expected 0", c, ready_o[0]); end
    end
  endtask

  task automatic test_reset_mid();
    loop_en = 0;
    tick();
    checks += 2;
    if (fcw_o[0] !== 24'h100000) begin errors++; $display("FAIL mid_open_fcw: got %h expected 100000", fcw_o[0]); end
    if (ready_o[0] !== 1'b0) begin errors++; $display("FAIL mid_open_ready: got %b expected 0", ready_o[0]); end
    rstn = 0; hold_req = 0; ctrl_valid = 1;
    tick();
    checks += 4;
    if (phase_o[0] !== 8'h00) begin errors++; $display("FAIL mid_reset_phase: got %h expected 00", phase_o[0]); end
    if (wrap_o[0] !== 1'b0) begin errors++; $display("FAIL mid_reset_wrap: got %b expected 0", wrap_o[0]); end
    if (dco_o[0] !== 1'b0) begin errors++; $display("FAIL mid_reset_dco: got %b expected 0", dco_o[0]); end
    if (fcw_o[0] !== 24'h100000) begin errors++; $display("FAIL mid_reset_fcw: got %h expected 100000", fcw_o[0]); end
    rstn = 1; ctrl_valid = 0;
    tick();
    checks++;
    if (phase_o[0] !== 8'h10) begin errors++; $display("FAIL mid_post_phase: got %h expected 10", phase_o[0]); end
  endtask

  task automatic test_back_to_back();
    loop_en = 1; hold_req = 0; ctrl_valid = 1;
    for (int c = 0; c < 24; c++) begin
      ctrl_in = 8'($urandom);
      tick();
      for (int i = 0; i < 2; i++) begin
        checks += 2;
        if (fcw_o[i] !== 24'(m_fcw[i])) begin errors++; $display("FAIL b2b_fcw[%0d] c%0d: got %h expected %h", i, c, fcw_o[i], 24'(m_fcw[i])); end
        if (sat_o[i] !== m_sat[i]) begin errors++; $display("FAIL b2b_sat[%0d] c%0d: got %b expected %b", i, c, sat_o[i], m_sat[i]); end
      end
    end
    ctrl_valid = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rstn       = ($urandom_range(63) != 0);
      loop_en    = ($urandom_range(15) != 0);
      hold_req   = ($urandom_range(3) == 0);
      ctrl_valid = $urandom_range(1);
      ctrl_in    = 8'($urandom);
      tick();
      for (int i = 0; i < 2; i++) begin
        checks += 6;
        if (fcw_o[i] !== 24'(m_fcw[i])) begin errors++; $display("FAIL rnd_fcw[%0d] c%0d: got %h expected %h", i, c, fcw_o[i], 24'(m_fcw[i])); end
        if (sat_o[i] !== m_sat[i]) begin errors++; $display("FAIL rnd_sat[%0d] c%0d: got %b expected %b", i, c, sat_o[i], m_sat[i]); end
        if (ready_o[i] !== (m_mode == 1)) begin errors++; $display("FAIL rnd_ready[%0d] c%0d: got %b expected %b", i, c, ready_o[i], m_mode == 1); end
        if (wrap_o[i] !== m_wrap[i]) begin errors++; $display("FAIL rnd_wrap[%0d] c%0d: got %b expected %b", i, c, wrap_o[i], m_wrap[i]); end
        if (phase_o[i] !== 8'(m_acc[i] >> 16)) begin errors++; $display("FAIL rnd_phase[%0d] c%0d: got %h expected %h", i, c, phase_o[i], 8'(m_acc[i] >> 16)); end
        if (dco_o[i] !== m_acc[i][23]) begin errors++; $display("FAIL rnd_dco[%0d] c%0d: got %b expected %b", i, c, dco_o[i], m_acc[i][23]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_open_run();
    test_track_basic();
    test_clamp();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
